// File: rtl/doorbell_pkg.sv
// Shared types and default timing constants for the doorbell chime path.
package doorbell_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DING = 2'd1,
    DONG = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam int unsigned DEF_DEBOUNCE_LEN = 4;
  localparam int unsigned DEF_DING_HALF    = 2;
  localparam int unsigned DEF_DONG_HALF    = 3;
  localparam int unsigned DEF_NOTE_LEN     = 20;
  localparam int unsigned DEF_GAP_LEN      = 10;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/doorbell_chime_seq_if.sv
// Button input plus tone/select/status outputs of the chime sequencer.
interface doorbell_chime_seq_if;
  logic button;
  logic tone_a;
  logic tone_b;
  logic sel;
  logic busy;
  logic done;

  modport master (output button, input tone_a, input tone_b, input sel, input busy, input done);
  modport slave  (input button, output tone_a, output tone_b, output sel, output busy, output done);
endinterface

// File: rtl/doorbell_chime_seq_btn_debounce.sv
// Two-flop synchroniser, stable-high debounce counter and rising-edge press pulse.
module btn_debounce
  import doorbell_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LEN = DEF_DEBOUNCE_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_i,
    output logic press_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_LEN);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;
    logic          db_prev_q;

    // Counter saturates at DEBOUNCE_LEN so a long hold never re-triggers.
    always_comb begin
        cnt_d = '0;
        db_d  = 1'b0;
        if (sync2_q) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            db_d  = db_q | (cnt_q == CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
        end else begin
            sync1_q   <= button_i;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            db_prev_q <= db_q;
        end
    end

    assign press_o = db_q & ~db_prev_q;

endmodule

// File: rtl/doorbell_chime_seq.sv
// Ding-dong sequencer: FSM, note counter and two tone dividers.
// Optional DOORBELL_REPEAT_EN queues one press made while busy.
module doorbell_chime_seq
  import doorbell_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LEN = DEF_DEBOUNCE_LEN,
    parameter int unsigned DING_HALF    = DEF_DING_HALF,
    parameter int unsigned DONG_HALF    = DEF_DONG_HALF,
    parameter int unsigned NOTE_LEN     = DEF_NOTE_LEN,
    parameter int unsigned GAP_LEN      = DEF_GAP_LEN
) (
    input logic               clk,
    input logic               rst_n,
    doorbell_chime_seq_if.slave bus
);

    localparam int unsigned NW = $clog2(max2(NOTE_LEN, GAP_LEN) + 1);
    localparam int unsigned AW = $clog2(DING_HALF + 1);
    localparam int unsigned BW = $clog2(DONG_HALF + 1);
    localparam logic [NW-1:0] NOTE_LAST = NW'(NOTE_LEN - 1);
    localparam logic [NW-1:0] GAP_LAST  = NW'(GAP_LEN - 1);
    localparam logic [AW-1:0] A_LAST    = AW'(DING_HALF - 1);
    localparam logic [BW-1:0] B_LAST    = BW'(DONG_HALF - 1);

    if (DEBOUNCE_LEN < 1 || DING_HALF < 1 || DONG_HALF < 1 || NOTE_LEN < 1 || GAP_LEN < 1) begin : g_param_check
        $error("doorbell_chime_seq: all length parameters must be >= 1");
    end

    state_e        state_q, state_d;
    logic [NW-1:0] note_q, note_d;
    logic [AW-1:0] diva_q, diva_d;
    logic [BW-1:0] divb_q, divb_d;
    logic          tone_a_q, tone_a_d;
    logic          tone_b_q, tone_b_d;
    logic          done_q, done_d;
    logic          press;
`ifdef DOORBELL_REPEAT_EN
    logic          pend_q, pend_d;
`endif

    btn_debounce #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .button_i (bus.button),
        .press_o  (press)
    );

    always_comb begin
        state_d  = state_q;
        note_d   = note_q + NW'(1);
        diva_d   = '0;
        divb_d   = '0;
        tone_a_d = 1'b0;
        tone_b_d = 1'b0;
        done_d   = 1'b0;
`ifdef DOORBELL_REPEAT_EN
        pend_d   = pend_q | (press & (state_q != IDLE));
`endif
        case (state_q)
            IDLE: begin
                note_d = '0;
                if (press) state_d = DING;
            end
            DING: begin
                diva_d   = (diva_q == A_LAST) ? '0 : diva_q + AW'(1);
                tone_a_d = (diva_q == A_LAST) ? ~tone_a_q : tone_a_q;
                if (note_q == NOTE_LAST) state_d = DONG;
            end
            DONG: begin
                divb_d   = (divb_q == B_LAST) ? '0 : divb_q + BW'(1);
                tone_b_d = (divb_q == B_LAST) ? ~tone_b_q : tone_b_q;
                if (note_q == NOTE_LAST) state_d = GAP;
            end
            GAP: begin
                if (note_q == GAP_LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef DOORBELL_REPEAT_EN
                    // A press landing on this very edge is honoured directly.
                    if (pend_q || press) begin
                        state_d = DING;
                        pend_d  = 1'b0;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        // Every state entry restarts the note counter and both tone dividers.
        if (state_d != state_q) begin
            note_d   = '0;
            diva_d   = '0;
            divb_d   = '0;
            tone_a_d = 1'b0;
            tone_b_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            note_q   <= '0;
            diva_q   <= '0;
            divb_q   <= '0;
            tone_a_q <= 1'b0;
            tone_b_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            note_q   <= note_d;
            diva_q   <= diva_d;
            divb_q   <= divb_d;
            tone_a_q <= tone_a_d;
            tone_b_q <= tone_b_d;
            done_q   <= done_d;
        end
    end

`ifdef DOORBELL_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= 1'b0;
        else        pend_q <= pend_d;
    end
`endif

    assign bus.tone_a = tone_a_q;
    assign bus.tone_b = tone_b_q;
    assign bus.sel    = (state_q == DONG);
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;

endmodule
